// File: rtl/jam_pkg.sv
// jam_pkg: widths and FSM state type shared by JAM and its cost table.
package jam_pkg;
    localparam int COST_W    = 7;
    localparam int N_WORKERS = 8;
    localparam int IDX_W     = 3;
    localparam int CHK_W     = 13;
    localparam int LB_W      = 10;
    typedef enum logic {LOAD, DONE} state_t;
endpackage

// File: rtl/jam_cost_mem.sv
// jam_cost_mem: 64-entry cost register file, one sync write port, one async read port.
module jam_cost_mem #(
    parameter int COST_W = 7
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              we,
    input  logic [5:0]        waddr,
    input  logic [COST_W-1:0] wdata,
    input  logic [5:0]        raddr,
    output logic [COST_W-1:0] rdata
);
    logic [COST_W-1:0] mem_q [64];

    always_ff @(posedge CLK or posedge RST)
        if (RST)
            for (int i = 0; i < 64; i++) mem_q[i] <= '0;
        else if (we)
            mem_q[waddr] <= wdata;

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/jam_cost_table.sv
// jam_cost_table: streams in the 8x8 JAM cost matrix, serves Cost combinationally, tracks Checksum.
// Defining JAM_COST_LB_EN adds the row-minimum LowerBound; otherwise LowerBound is 0.
module jam_cost_table import jam_pkg::*; #(
    parameter int COST_W = 7
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              InValid,
    output logic              InReady,
    input  logic [COST_W-1:0] InData,
    input  logic              Clear,
    input  logic [IDX_W-1:0]  W,
    input  logic [IDX_W-1:0]  J,
    output logic [COST_W-1:0] Cost,
    output logic              Loaded,
    output logic [CHK_W-1:0]  Checksum,
    output logic [LB_W-1:0]   LowerBound
);
    state_t           state_q, state_d;
    logic [5:0]       addr_q, addr_d;
    logic [CHK_W-1:0] chk_q, chk_d;
    logic             accept;

    assign accept = InValid & InReady;

    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            state_q <= LOAD;
            addr_q  <= '0;
            chk_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            chk_q   <= chk_d;
        end

    always_comb begin
        state_d = Clear ? LOAD : (accept && addr_q == 6'd63) ? DONE : state_q;
        addr_d  = Clear ? '0 : accept ? addr_q + 6'd1 : addr_q;
        chk_d   = Clear ? '0 : accept ? chk_q + CHK_W'(InData) : chk_q;
    end

    always_comb begin
        InReady = state_q == LOAD && !Clear;
        Loaded  = state_q == DONE;
    end

    assign Checksum = chk_q;

    jam_cost_mem #(.COST_W(COST_W)) u_mem (
        .CLK   (CLK),
        .RST   (RST),
        .we    (accept),
        .waddr (addr_q),
        .wdata (InData),
        .raddr ({W, J}),
        .rdata (Cost)
    );

`ifdef JAM_COST_LB_EN
    logic [COST_W-1:0] rowmin_q [N_WORKERS];
    logic [COST_W-1:0] row_m;
    logic [LB_W-1:0]   lb_q;

    // Job 0 starts a fresh row minimum; job 7 folds the finished row into the bound.
    assign row_m = (addr_q[2:0] == 3'd0 || InData < rowmin_q[addr_q[5:3]]) ? InData : rowmin_q[addr_q[5:3]];

    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            for (int i = 0; i < N_WORKERS; i++) rowmin_q[i] <= '0;
            lb_q <= '0;
        end else if (Clear) begin
            lb_q <= '0;
        end else if (accept) begin
            rowmin_q[addr_q[5:3]] <= row_m;
            if (addr_q[2:0] == 3'd7) lb_q <= lb_q + LB_W'(row_m);
        end

    assign LowerBound = lb_q;
`else
    assign LowerBound = '0;
`endif
endmodule

// File: tb/tb_jam_cost_table.sv
// tb_jam_cost_table: directed and randomized loads checked against a matrix-level reference model.
module tb_jam_cost_table;
    logic       CLK = 0, RST = 1, InValid = 0, Clear = 0;
    logic [6:0] InData = 0;
    logic [2:0] W = 0, J = 0;
    logic       InReady, Loaded;
    logic [6:0] Cost;
    logic [12:0] Checksum;
    logic [9:0]  LowerBound;

    jam_cost_table dut (
        .CLK(CLK), .RST(RST), .InValid(InValid), .InReady(InReady), .InData(InData),
        .Clear(Clear), .W(W), .J(J), .Cost(Cost), .Loaded(Loaded),
        .Checksum(Checksum), .LowerBound(LowerBound)
    );

    always #5 CLK = ~CLK;

    int checks = 0, failures = 0;
    int exp_mem [64];
    int cnt, mchk;
    bit mloaded;

    task automatic check(string tag, logic [31:0] obs, int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int lb_model();
        int s = 0;
`ifdef JAM_COST_LB_EN
        for (int r = 0; r < 8; r++) begin
            int m = exp_mem[r*8];
            for (int c = 1; c < 8; c++) if (exp_mem[r*8+c] < m) m = exp_mem[r*8+c];
            s += m;
        end
`endif
        return s;
    endfunction

    task automatic reset_model();
        foreach (exp_mem[i]) exp_mem[i] = 0;
        cnt = 0; mchk = 0; mloaded = 0;
    endtask

    task automatic check_outputs(string tag);
        W = 3'($urandom); J = 3'($urandom); #1;
        check({tag, ":cost"}, Cost, exp_mem[int'(W)*8 + int'(J)]);
        check({tag, ":loaded"}, Loaded, mloaded);
        check({tag, ":checksum"}, Checksum, mchk);
        if (mloaded) check({tag, ":lowerbound"}, LowerBound, lb_model());
    endtask

    task automatic beat(bit v, logic [6:0] d, bit c);
        bit acc;
        InValid = v; InData = d; Clear = c; #1;
        check("inready", InReady, (!c && !mloaded) ? 1 : 0);
        acc = v && !c && !mloaded;
        if (c) begin
            cnt = 0; mchk = 0; mloaded = 0;
        end else if (acc) begin
            exp_mem[cnt] = d; mchk += d; cnt++;
            if (cnt == 64) begin mloaded = 1; cnt = 0; end
        end
        @(posedge CLK); #1;
        InValid = 0; Clear = 0;
        check_outputs("beat");
    endtask

    // kind: 0 data=beat index, 1 all 127, 2 random; gap: 0 none, 1 every other cycle, 2 random
    task automatic load(int kind, int gap);
        int guard = 0;
        bit v;
        logic [6:0] d;
        while (!mloaded && guard < 1000) begin
            v = gap == 0 ? 1'b1 : gap == 1 ? (guard % 2 == 0) : ($urandom_range(0, 2) != 0);
            d = kind == 0 ? 7'(cnt) : kind == 1 ? 7'd127 : 7'($urandom_range(0, 127));
            beat(v, d, 0);
            guard++;
        end
        check("load_bound", Loaded, 1);
    endtask

    initial begin
        reset_model();
        repeat (2) @(posedge CLK);
        @(negedge CLK); RST = 0; #1;
        check("rst:inready", InReady, 1);
        check("rst:loaded", Loaded, 0);
        check("rst:checksum", Checksum, 0);
        check("rst:lowerbound", LowerBound, 0);
        W = 7; J = 7; #1;
        check("rst:cost77", Cost, 0);

        load(0, 0);
        check("seq:checksum", Checksum, 2016);
`ifdef JAM_COST_LB_EN
        check("seq:lowerbound", LowerBound, 224);
`else
        check("seq:lowerbound", LowerBound, 0);
`endif
        W = 5; J = 3; #1;
        check("seq:cost53", Cost, 43);

        repeat (5) beat(1, 0, 0);
        check("done:checksum", Checksum, 2016);
        W = 7; J = 7; #1;
        check("done:cost77", Cost, 63);

        beat(0, 0, 1);
        load(0, 1);
        check("gap:checksum", Checksum, 2016);

        beat(0, 0, 1);
        repeat (20) beat(1, 7'($urandom_range(0, 127)), 0);
        beat(1, 7'd55, 1);
        check("clr:checksum", Checksum, 0);
        check("clr:loaded", Loaded, 0);
        load(1, 2);
        check("max:checksum", Checksum, 8128);
`ifdef JAM_COST_LB_EN
        check("max:lowerbound", LowerBound, 1016);
`else
        check("max:lowerbound", LowerBound, 0);
`endif

        repeat (3) begin
            beat(0, 0, 1);
            load(2, 2);
        end

        beat(0, 0, 1);
        repeat (30) beat(1, 7'($urandom_range(1, 127)), 0);
        InValid = 1; InData = 7'($urandom_range(0, 127)); #2;
        RST = 1; #1;
        reset_model();
        check("arst:inready", InReady, 1);
        check("arst:loaded", Loaded, 0);
        check("arst:checksum", Checksum, 0);
        check("arst:lowerbound", LowerBound, 0);
        check_outputs("arst");
        @(negedge CLK); RST = 0; InValid = 0; #1;
        load(2, 2);
        load(2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
